uart_tx_fifo: RTL and testbench

Byte buffer and scheduler that sits directly upstream of `uart_tx`. It accepts bytes from the USB-side logic at any rate into a DEPTH-entry FIFO. It hands bytes to `uart_tx` one at a time using that block's `i_TX_DV`/`i_TX_Byte` strobe interface, and waits for `o_TX_Done` before issuing the next byte. The producer never has to track serial-line timing; it only has to respect `o_Full`.

---
 rtl/uart_tx_fifo_if.sv | 23 ++
 rtl/uart_tx_fifo.sv | 65 ++++++
 tb/tb_uart_tx_fifo.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: write-side and uart_tx-side handshake signals of the byte scheduler.
interface uart_tx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic              i_WR_DV;
  logic [7:0]        i_WR_Byte;
  logic              o_Full;
  logic              o_Empty;
  logic [ADDR_W:0]   o_Count;
  logic              o_Overflow;
  logic              o_TX_DV;
  logic [7:0]        o_TX_Byte;
  logic              i_TX_Active;
  logic              i_TX_Done;
  modport slave (
    input  i_WR_DV, i_WR_Byte, i_TX_Active, i_TX_Done,
    output o_Full, o_Empty, o_Count, o_Overflow, o_TX_DV, o_TX_Byte
  );
  modport master (
    output i_WR_DV, i_WR_Byte, i_TX_Active, i_TX_Done,
    input  o_Full, o_Empty, o_Count, o_Overflow, o_TX_DV, o_TX_Byte
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that issues one byte per uart_tx frame, waiting for done between issues.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic         i_Clock,
  input  logic         i_Reset,
  uart_tx_fifo_if.slave bus
);
  typedef enum logic {S_IDLE, S_WAIT} state_e;
  state_e            state_q, state_d;
  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d, empty_q, empty_d;
  logic              ovf_q, ovf_d, dv_q, dv_d;
  logic [7:0]        byte_q, byte_d;
  logic              wr_ok, pop;
  always_comb begin
    wr_ok    = bus.i_WR_DV && !full_q;
    pop      = (state_q == S_IDLE) && !empty_q && !bus.i_TX_Active;
    state_d  = pop ? S_WAIT : ((state_q == S_WAIT) && bus.i_TX_Done) ? S_IDLE : state_q;
    wr_ptr_d = wr_ptr_q + ADDR_W'(wr_ok);
    rd_ptr_d = rd_ptr_q + ADDR_W'(pop);
    count_d  = count_q + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(pop);
    full_d   = count_d == (ADDR_W+1)'(DEPTH);
    empty_d  = count_d == '0;
    ovf_d    = bus.i_WR_DV && full_q;
    dv_d     = pop;
    byte_d   = pop ? mem_q[rd_ptr_q] : byte_q;
  end
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      dv_q     <= 1'b0;
      byte_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      dv_q     <= dv_d;
      byte_q   <= byte_d;
    end
  end
  // storage is deliberately left out of reset
  always_ff @(posedge i_Clock) begin
    if (wr_ok) mem_q[wr_ptr_q] <= bus.i_WR_Byte;
  end
  assign bus.o_Full     = full_q;
  assign bus.o_Empty    = empty_q;
  assign bus.o_Count    = count_q;
  assign bus.o_Overflow = ovf_q;
  assign bus.o_TX_DV    = dv_q;
  assign bus.o_TX_Byte  = byte_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: table vectors, directed corner sequences and random traffic against a queue model.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16, ADDR_W = 4;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  uart_tx_fifo_if #(.ADDR_W(ADDR_W)) bus ();
  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (.i_Clock(clk), .i_Reset(rst), .bus(bus));
  int tests = 0, fails = 0;
  logic [7:0] mq[$];
  logic [7:0] issued[$];
  logic [7:0] m_byte = 8'h00;
  bit m_wait = 0, m_dv = 0, m_ovf = 0, prev_dv = 0, noise = 0;
  int busy = 0;
  typedef struct {
    logic wr; logic [7:0] b; logic act, done;
    logic [4:0] cnt; logic emp, full, ovf, dv; logic [7:0] byt;
  } vec_t;
  vec_t tbl[14];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic model_edge(input logic wr, input logic [7:0] b, input logic act, input logic done);
    bit full_b, pop;
    full_b = mq.size() == DEPTH;
    pop = !m_wait && mq.size() != 0 && !act;
    m_ovf = wr && full_b;
    m_dv = pop;
    if (pop) begin
      m_byte = mq.pop_front();
      m_wait = 1;
    end else if (m_wait && done) m_wait = 0;
    if (wr && !full_b) mq.push_back(b);
  endtask
  task automatic model_reset();
    mq.delete();
    m_wait = 0; m_dv = 0; m_ovf = 0; m_byte = 8'h00; prev_dv = 0;
  endtask
  task automatic step(input logic wr, input logic [7:0] b, input logic act, input logic done);
    bus.i_WR_DV = wr; bus.i_WR_Byte = b; bus.i_TX_Active = act; bus.i_TX_Done = done;
    @(posedge clk);
    model_edge(wr, b, act, done);
    #1;
    chk("count", 32'(bus.o_Count), 32'(mq.size()));
    chk("empty", 32'(bus.o_Empty), 32'(mq.size() == 0));
    chk("full", 32'(bus.o_Full), 32'(mq.size() == DEPTH));
    chk("overflow", 32'(bus.o_Overflow), 32'(m_ovf));
    chk("tx_dv", 32'(bus.o_TX_DV), 32'(m_dv));
    chk("tx_byte", 32'(bus.o_TX_Byte), 32'(m_byte));
    chk("dv_gap", 32'(prev_dv & bus.o_TX_DV), 32'(0));
    if (bus.o_TX_DV === 1'b1) issued.push_back(bus.o_TX_Byte);
    prev_dv = bus.o_TX_DV;
  endtask
  task automatic auto_step(input logic wr, input logic [7:0] b);
    logic act, done;
    act = busy > 1;
    done = busy == 1;
    if (busy == 0) begin
      act = noise && ($urandom % 8 == 0);
      done = noise && ($urandom % 16 == 0);
    end else busy--;
    step(wr, b, act, done);
    if (bus.o_TX_DV === 1'b1) busy = noise ? int'($urandom_range(1, 8)) : 3;
  endtask
  task automatic do_reset();
    bus.i_WR_DV = 0; bus.i_WR_Byte = 8'h00; bus.i_TX_Active = 0; bus.i_TX_Done = 0;
    #2 rst = 1'b1;
    #1;
    chk("rst_count", 32'(bus.o_Count), 32'(0));
    chk("rst_empty", 32'(bus.o_Empty), 32'(1));
    chk("rst_full", 32'(bus.o_Full), 32'(0));
    chk("rst_ovf", 32'(bus.o_Overflow), 32'(0));
    chk("rst_dv", 32'(bus.o_TX_DV), 32'(0));
    chk("rst_byte", 32'(bus.o_TX_Byte), 32'(0));
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl[0]  = '{1, 8'hA1, 1, 0, 5'd1, 0, 0, 0, 0, 8'h00};
    tbl[1]  = '{1, 8'hB2, 1, 0, 5'd2, 0, 0, 0, 0, 8'h00};
    tbl[2]  = '{0, 8'h00, 0, 0, 5'd1, 0, 0, 0, 1, 8'hA1};
    tbl[3]  = '{0, 8'h00, 1, 0, 5'd1, 0, 0, 0, 0, 8'hA1};
    tbl[4]  = '{1, 8'hC3, 1, 1, 5'd2, 0, 0, 0, 0, 8'hA1};
    tbl[5]  = '{1, 8'hD4, 0, 0, 5'd2, 0, 0, 0, 1, 8'hB2};
    tbl[6]  = '{0, 8'h00, 0, 0, 5'd2, 0, 0, 0, 0, 8'hB2};
    tbl[7]  = '{0, 8'h00, 0, 1, 5'd2, 0, 0, 0, 0, 8'hB2};
    tbl[8]  = '{0, 8'h00, 0, 0, 5'd1, 0, 0, 0, 1, 8'hC3};
    tbl[9]  = '{0, 8'h00, 0, 1, 5'd1, 0, 0, 0, 0, 8'hC3};
    tbl[10] = '{0, 8'h00, 0, 0, 5'd0, 1, 0, 0, 1, 8'hD4};
    tbl[11] = '{0, 8'h00, 0, 1, 5'd0, 1, 0, 0, 0, 8'hD4};
    tbl[12] = '{0, 8'h00, 0, 1, 5'd0, 1, 0, 0, 0, 8'hD4};
    tbl[13] = '{0, 8'h00, 0, 0, 5'd0, 1, 0, 0, 0, 8'hD4};
    bus.i_WR_DV = 0; bus.i_WR_Byte = 8'h00; bus.i_TX_Active = 0; bus.i_TX_Done = 0;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].wr, tbl[i].b, tbl[i].act, tbl[i].done);
      chk($sformatf("tbl%0d_cnt", i), 32'(bus.o_Count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_empty", i), 32'(bus.o_Empty), 32'(tbl[i].emp));
      chk($sformatf("tbl%0d_full", i), 32'(bus.o_Full), 32'(tbl[i].full));
      chk($sformatf("tbl%0d_ovf", i), 32'(bus.o_Overflow), 32'(tbl[i].ovf));
      chk($sformatf("tbl%0d_dv", i), 32'(bus.o_TX_DV), 32'(tbl[i].dv));
      chk($sformatf("tbl%0d_byte", i), 32'(bus.o_TX_Byte), 32'(tbl[i].byt));
    end
    step(1, 8'h41, 0, 0);
    chk("single_cnt", 32'(bus.o_Count), 32'(1));
    chk("single_dv_early", 32'(bus.o_TX_DV), 32'(0));
    step(0, 8'h00, 0, 0);
    chk("single_dv", 32'(bus.o_TX_DV), 32'(1));
    chk("single_byte", 32'(bus.o_TX_Byte), 32'(8'h41));
    chk("single_cnt0", 32'(bus.o_Count), 32'(0));
    step(0, 8'h00, 0, 1);
    chk("single_dv_off", 32'(bus.o_TX_DV), 32'(0));
    for (int i = 0; i < 17; i++) begin
      step(1, 8'(i), 1, 0);
      if (i == 15) begin
        chk("fill_cnt16", 32'(bus.o_Count), 32'(16));
        chk("fill_full", 32'(bus.o_Full), 32'(1));
      end
    end
    chk("ovf_pulse", 32'(bus.o_Overflow), 32'(1));
    chk("ovf_cnt", 32'(bus.o_Count), 32'(16));
    step(0, 8'h00, 1, 0);
    chk("ovf_one_cycle", 32'(bus.o_Overflow), 32'(0));
    issued.delete();
    busy = 0;
    for (int i = 0; i < 400 && issued.size() < 16; i++) auto_step(0, 8'h00);
    repeat (6) auto_step(0, 8'h00);
    chk("drain_n", 32'(issued.size()), 32'(16));
    for (int i = 0; i < 16 && i < issued.size(); i++) chk($sformatf("drain_%0d", i), 32'(issued[i]), 32'(i));
    chk("drain_cnt", 32'(bus.o_Count), 32'(0));
    for (int i = 0; i < 3; i++) step(1, 8'hA0 + 8'(i), 1, 0);
    for (int k = 0; k < 20; k++) begin
      step(1, 8'hB0 + 8'(k), 0, 0);
      chk($sformatf("simul_cnt%0d", k), 32'(bus.o_Count), 32'(3));
      chk($sformatf("simul_dv%0d", k), 32'(bus.o_TX_DV), 32'(1));
      chk($sformatf("simul_byte%0d", k), 32'(bus.o_TX_Byte), 32'(k < 3 ? 8'hA0 + 8'(k) : 8'hB0 + 8'(k - 3)));
      step(0, 8'h00, 0, 1);
    end
    busy = 0;
    for (int i = 0; i < 100 && !(bus.o_Empty === 1'b1 && busy == 0); i++) auto_step(0, 8'h00);
    chk("simul_drained", 32'(bus.o_Empty), 32'(1));
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 1);
    chk("stray_dv", 32'(bus.o_TX_DV), 32'(0));
    chk("stray_empty", 32'(bus.o_Empty), 32'(1));
    step(0, 8'h00, 0, 0);
    chk("stray_dv2", 32'(bus.o_TX_DV), 32'(0));
    for (int i = 0; i < 6; i++) step(1, 8'h60 + 8'(i), 1, 0);
    step(0, 8'h00, 0, 0);
    chk("mid_cnt5", 32'(bus.o_Count), 32'(5));
    step(0, 8'h00, 1, 0);
    do_reset();
    step(0, 8'h00, 0, 1);
    chk("mid_trail_dv", 32'(bus.o_TX_DV), 32'(0));
    chk("mid_trail_cnt", 32'(bus.o_Count), 32'(0));
    step(0, 8'h00, 0, 0);
    chk("mid_idle_dv", 32'(bus.o_TX_DV), 32'(0));
    step(1, 8'h42, 0, 0);
    step(0, 8'h00, 0, 0);
    chk("mid_new_dv", 32'(bus.o_TX_DV), 32'(1));
    chk("mid_new_byte", 32'(bus.o_TX_Byte), 32'(8'h42));
    step(0, 8'h00, 0, 1);
    noise = 1;
    busy = 0;
    for (int i = 0; i < 3000; i++) begin
      logic w;
      w = (i % 600 < 300) ? ($urandom % 4 != 0) : ($urandom % 5 == 0);
      if (i == 1500) do_reset();
      auto_step(w, 8'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
